fpu_ss_wb_arbiter: RTL and testbench

FPU_SS_WB_ARBITER -- requirements
Module: fpu_ss_wb_arbiter

---
 rtl/fpu_ss_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpu_ss_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_wb_arbiter.sv
// fpu_ss_wb_arbiter: merges FPU results and memory completions into one
// core result slot, and issues FP register file writes for both sources.
// Optional feature macro: FPU_SS_WB_FIXED_PRIO_EN (memory always wins ties).
module fpu_ss_wb_arbiter #(
   parameter int unsigned X_ID_WIDTH = 4,
   parameter int unsigned FLEN       = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   // FPU source
   input  logic                  fpu_out_valid_i,
   output logic                  fpu_out_ready_o,
   input  logic [FLEN-1:0]       fpu_result_i,
   input  logic [4:0]            fpu_tag_addr_i,
   input  logic                  fpu_tag_rd_is_fp_i,
   input  logic [X_ID_WIDTH-1:0] fpu_tag_id_i,
   // memory source
   input  logic                  mem_valid_i,
   output logic                  mem_ready_o,
   input  logic [FLEN-1:0]       mem_rdata_i,
   input  logic [X_ID_WIDTH-1:0] mem_id_i,
   input  logic [4:0]            mem_rd_i,
   input  logic                  mem_we_i,
   // FP register file write
   output logic                  fpr_we_o,
   output logic [4:0]            fpr_waddr_o,
   output logic [FLEN-1:0]       fpr_wdata_o,
   // core result channel
   output logic                  x_result_valid_o,
   input  logic                  x_result_ready_i,
   output logic [X_ID_WIDTH-1:0] x_result_id_o,
   output logic [31:0]           x_result_data_o,
   output logic [4:0]            x_result_rd_o,
   output logic                  x_result_we_o
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic [XLEN-1:0]       data;
      logic [AW-1:0]         rd;
      logic                  we;
   } slot_t;

   slot_t             slot_q, slot_d;
   logic              res_valid_q, res_valid_d;
   logic              fpr_we_q, fpr_we_d;
   logic [AW-1:0]     fpr_waddr_q, fpr_waddr_d;
   logic [FLEN-1:0]   fpr_wdata_q, fpr_wdata_d;
   logic              slot_free;
   logic              gnt_fpu, gnt_mem;

`ifndef FPU_SS_WB_FIXED_PRIO_EN
   typedef enum logic {GRANT_FPU = 1'b0, GRANT_MEM = 1'b1} grant_e;
   grant_e            last_grant_q, last_grant_d;
`endif

   // Grant selection: one source per cycle, only into a free slot, never in reset
   always_comb begin
      slot_free = !res_valid_q || x_result_ready_i;
      gnt_fpu   = 1'b0;
      gnt_mem   = 1'b0;
      if (rst_ni && slot_free) begin
         if (fpu_out_valid_i && mem_valid_i) begin
`ifdef FPU_SS_WB_FIXED_PRIO_EN
            gnt_mem = 1'b1;
`else
            if (last_grant_q == GRANT_MEM) gnt_fpu = 1'b1;
            else                           gnt_mem = 1'b1;
`endif
         end else begin
            gnt_fpu = fpu_out_valid_i;
            gnt_mem = mem_valid_i;
         end
      end
   end

   // Next-state for the result slot, FP write port and round-robin pointer
   always_comb begin
      slot_d      = slot_q;
      res_valid_d = res_valid_q;
      fpr_we_d    = 1'b0;
      fpr_waddr_d = fpr_waddr_q;
      fpr_wdata_d = fpr_wdata_q;
`ifndef FPU_SS_WB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      if (x_result_ready_i) res_valid_d = 1'b0;
      if (gnt_fpu) begin
         res_valid_d  = 1'b1;
         slot_d.id    = fpu_tag_id_i;
         slot_d.data  = XLEN'(fpu_result_i);
         slot_d.rd    = fpu_tag_addr_i;
         slot_d.we    = !fpu_tag_rd_is_fp_i;
         if (fpu_tag_rd_is_fp_i) begin
            fpr_we_d    = 1'b1;
            fpr_waddr_d = fpu_tag_addr_i;
            fpr_wdata_d = fpu_result_i;
         end
`ifndef FPU_SS_WB_FIXED_PRIO_EN
         last_grant_d = GRANT_FPU;
`endif
      end else if (gnt_mem) begin
         res_valid_d  = 1'b1;
         slot_d.id    = mem_id_i;
         slot_d.data  = '0;
         slot_d.rd    = mem_rd_i;
         slot_d.we    = 1'b0;
         if (mem_we_i) begin
            fpr_we_d    = 1'b1;
            fpr_waddr_d = mem_rd_i;
            fpr_wdata_d = mem_rdata_i;
         end
`ifndef FPU_SS_WB_FIXED_PRIO_EN
         last_grant_d = GRANT_MEM;
`endif
      end
   end

   // State registers; reset discards any pending result or FP write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q       <= '0;
         res_valid_q  <= 1'b0;
         fpr_we_q     <= 1'b0;
         fpr_waddr_q  <= '0;
         fpr_wdata_q  <= '0;
`ifndef FPU_SS_WB_FIXED_PRIO_EN
         last_grant_q <= GRANT_MEM;
`endif
      end else begin
         slot_q       <= slot_d;
         res_valid_q  <= res_valid_d;
         fpr_we_q     <= fpr_we_d;
         fpr_waddr_q  <= fpr_waddr_d;
         fpr_wdata_q  <= fpr_wdata_d;
`ifndef FPU_SS_WB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign fpu_out_ready_o  = gnt_fpu;
   assign mem_ready_o      = gnt_mem;
   assign fpr_we_o         = fpr_we_q;
   assign fpr_waddr_o      = fpr_waddr_q;
   assign fpr_wdata_o      = fpr_wdata_q;
   assign x_result_valid_o = res_valid_q;
   assign x_result_id_o    = slot_q.id;
   assign x_result_data_o  = slot_q.data;
   assign x_result_rd_o    = slot_q.rd;
   assign x_result_we_o    = slot_q.we;

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed bench for fpu_ss_wb_arbiter (honours FPU_SS_WB_FIXED_PRIO_EN).
module tb_fpu_ss_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        fpu_out_valid_i, fpu_out_ready_o;
   logic [31:0] fpu_result_i;
   logic [4:0]  fpu_tag_addr_i;
   logic        fpu_tag_rd_is_fp_i;
   logic [3:0]  fpu_tag_id_i;
   logic        mem_valid_i, mem_ready_o;
   logic [31:0] mem_rdata_i;
   logic [3:0]  mem_id_i;
   logic [4:0]  mem_rd_i;
   logic        mem_we_i;
   logic        fpr_we_o;
   logic [4:0]  fpr_waddr_o;
   logic [31:0] fpr_wdata_o;
   logic        x_result_valid_o, x_result_ready_i;
   logic [3:0]  x_result_id_o;
   logic [31:0] x_result_data_o;
   logic [4:0]  x_result_rd_o;
   logic        x_result_we_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic exp_fpu;

   fpu_ss_wb_arbiter #(.X_ID_WIDTH(4), .FLEN(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
      .fpu_result_i(fpu_result_i), .fpu_tag_addr_i(fpu_tag_addr_i),
      .fpu_tag_rd_is_fp_i(fpu_tag_rd_is_fp_i), .fpu_tag_id_i(fpu_tag_id_i),
      .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
      .mem_rdata_i(mem_rdata_i), .mem_id_i(mem_id_i), .mem_rd_i(mem_rd_i),
      .mem_we_i(mem_we_i),
      .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o),
      .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
      .x_result_id_o(x_result_id_o), .x_result_data_o(x_result_data_o),
      .x_result_rd_o(x_result_rd_o), .x_result_we_o(x_result_we_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample point: 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(x_result_valid_o), 64'd0);
      chk({tag, "_id"},    64'(x_result_id_o),    64'd0);
      chk({tag, "_data"},  64'(x_result_data_o),  64'd0);
      chk({tag, "_rd"},    64'(x_result_rd_o),    64'd0);
      chk({tag, "_we"},    64'(x_result_we_o),    64'd0);
      chk({tag, "_fprwe"}, 64'(fpr_we_o),         64'd0);
      chk({tag, "_fprwa"}, 64'(fpr_waddr_o),      64'd0);
      chk({tag, "_fprwd"}, 64'(fpr_wdata_o),      64'd0);
      chk({tag, "_frdy"},  64'(fpu_out_ready_o),  64'd0);
      chk({tag, "_mrdy"},  64'(mem_ready_o),      64'd0);
   endtask

   initial begin
      rst_ni = 1'b0;
      fpu_out_valid_i = 1'b0; fpu_result_i = '0; fpu_tag_addr_i = '0;
      fpu_tag_rd_is_fp_i = 1'b0; fpu_tag_id_i = '0;
      mem_valid_i = 1'b0; mem_rdata_i = '0; mem_id_i = '0; mem_rd_i = '0; mem_we_i = 1'b0;
      x_result_ready_i = 1'b0;

      // Reset: outputs zero even with both sources requesting
      tick();
      fpu_out_valid_i = 1'b1; mem_valid_i = 1'b1; x_result_ready_i = 1'b1;
      #1;
      chk_all_zero("rst");
      fpu_out_valid_i = 1'b0; mem_valid_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();

      // Scenario 1: FPU result to FP register
      fpu_out_valid_i = 1'b1; fpu_tag_id_i = 4'd3; fpu_tag_addr_i = 5'd7;
      fpu_tag_rd_is_fp_i = 1'b1; fpu_result_i = 32'h3F80_0000;
      #1;
      chk("s1_frdy", 64'(fpu_out_ready_o), 64'd1);
      chk("s1_mrdy", 64'(mem_ready_o), 64'd0);
      tick();
      fpu_out_valid_i = 1'b0;
      chk("s1_fprwe", 64'(fpr_we_o), 64'd1);
      chk("s1_fprwa", 64'(fpr_waddr_o), 64'd7);
      chk("s1_fprwd", 64'(fpr_wdata_o), 64'h3F80_0000);
      chk("s1_valid", 64'(x_result_valid_o), 64'd1);
      chk("s1_id",    64'(x_result_id_o), 64'd3);
      chk("s1_we",    64'(x_result_we_o), 64'd0);
      tick();
      chk("s1_pulse", 64'(fpr_we_o), 64'd0);
      chk("s1_drain", 64'(x_result_valid_o), 64'd0);

      // Scenario 2: FPU result to integer register (e.g. FEQ)
      fpu_out_valid_i = 1'b1; fpu_tag_id_i = 4'd5; fpu_tag_addr_i = 5'd10;
      fpu_tag_rd_is_fp_i = 1'b0; fpu_result_i = 32'h0000_0001;
      tick();
      fpu_out_valid_i = 1'b0;
      chk("s2_fprwe", 64'(fpr_we_o), 64'd0);
      chk("s2_valid", 64'(x_result_valid_o), 64'd1);
      chk("s2_we",    64'(x_result_we_o), 64'd1);
      chk("s2_rd",    64'(x_result_rd_o), 64'd10);
      chk("s2_data",  64'(x_result_data_o), 64'd1);
      chk("s2_id",    64'(x_result_id_o), 64'd5);
      tick();

      // Scenario 3: both valid from reset state, back-to-back grants
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      fpu_out_valid_i = 1'b1; fpu_tag_id_i = 4'd1; fpu_tag_rd_is_fp_i = 1'b1;
      fpu_tag_addr_i = 5'd4; fpu_result_i = 32'h1111_1111;
      mem_valid_i = 1'b1; mem_id_i = 4'd2; mem_we_i = 1'b0; mem_rd_i = 5'd6;
      for (int i = 0; i < 4; i++) begin
`ifdef FPU_SS_WB_FIXED_PRIO_EN
         exp_fpu = 1'b0;
`else
         exp_fpu = (i % 2 == 0);
`endif
         #1;
         chk($sformatf("s3_frdy%0d", i), 64'(fpu_out_ready_o), 64'(exp_fpu));
         chk($sformatf("s3_mrdy%0d", i), 64'(mem_ready_o), 64'(!exp_fpu));
         tick();
         chk($sformatf("s3_valid%0d", i), 64'(x_result_valid_o), 64'd1);
         chk($sformatf("s3_id%0d", i), 64'(x_result_id_o), exp_fpu ? 64'd1 : 64'd2);
         chk($sformatf("s3_fprwe%0d", i), 64'(fpr_we_o), 64'(exp_fpu));
      end
      fpu_out_valid_i = 1'b0; mem_valid_i = 1'b0;
      tick();

      // Scenario 4: stall with slot full, then release
      x_result_ready_i = 1'b0;
      fpu_out_valid_i = 1'b1; fpu_tag_id_i = 4'd4; fpu_tag_addr_i = 5'd3;
      fpu_tag_rd_is_fp_i = 1'b0; fpu_result_i = 32'h0000_00AA;
      tick();
      fpu_out_valid_i = 1'b0;
      mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_rd_i = 5'd2;
      mem_rdata_i = 32'h4000_0000; mem_id_i = 4'd6;
      #1;
      chk("s4_mrdy_stall", 64'(mem_ready_o), 64'd0);
      tick();
      chk("s4_mrdy_hold",  64'(mem_ready_o), 64'd0);
      chk("s4_valid", 64'(x_result_valid_o), 64'd1);
      chk("s4_id",    64'(x_result_id_o), 64'd4);
      chk("s4_rd",    64'(x_result_rd_o), 64'd3);
      chk("s4_data",  64'(x_result_data_o), 64'hAA);
      chk("s4_we",    64'(x_result_we_o), 64'd1);
      chk("s4_fprwe", 64'(fpr_we_o), 64'd0);
      x_result_ready_i = 1'b1;
      #1;
      chk("s4_mrdy_go", 64'(mem_ready_o), 64'd1);
      tick();
      mem_valid_i = 1'b0;
      chk("s4_fprwe2", 64'(fpr_we_o), 64'd1);
      chk("s4_fprwa2", 64'(fpr_waddr_o), 64'd2);
      chk("s4_fprwd2", 64'(fpr_wdata_o), 64'h4000_0000);
      chk("s4_id2",    64'(x_result_id_o), 64'd6);
      chk("s4_data2",  64'(x_result_data_o), 64'd0);
      chk("s4_we2",    64'(x_result_we_o), 64'd0);

      // Scenario 5: store completion, then reset while result pending
      mem_valid_i = 1'b1; mem_we_i = 1'b0; mem_id_i = 4'd9; mem_rd_i = 5'd5;
      mem_rdata_i = 32'hDEAD_BEEF;
      tick();
      mem_valid_i = 1'b0; x_result_ready_i = 1'b0;
      chk("s5_fprwe", 64'(fpr_we_o), 64'd0);
      chk("s5_valid", 64'(x_result_valid_o), 64'd1);
      chk("s5_id",    64'(x_result_id_o), 64'd9);
      chk("s5_we",    64'(x_result_we_o), 64'd0);
      rst_ni = 1'b0;
      #1;
      chk_all_zero("s5_rst");
      tick();
      rst_ni = 1'b1;
      tick();
      chk("s5_post_valid", 64'(x_result_valid_o), 64'd0);
      chk("s5_post_fprwe", 64'(fpr_we_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
